// File: rtl/ext_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ext_pkg : shared types for the registered extension stage             |
// | Rev 1.0 : initial release                                             |
// +-----------------------------------------------------------------------+
package ext_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    EXT_ZERO = 3'b000,
    EXT_SIGN = 3'b001,
    EXT_LUI  = 3'b010,
    EXT_BOFF = 3'b011,
    EXT_LB   = 3'b100,
    EXT_LBU  = 3'b101,
    EXT_LH   = 3'b110,
    EXT_LHU  = 3'b111
  } ext_mode_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

endpackage
`default_nettype wire

// File: rtl/ext_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ext_if : producer/consumer handshake bundle around ext_stage          |
// | Rev 1.0 : initial release                                             |
// +-----------------------------------------------------------------------+
interface ext_if
  import ext_pkg::*;
#(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32,
  parameter int OFF_W  = $clog2(DATA_W/8)
);
  logic              in_valid;
  logic              in_ready;
  logic [MODE_W-1:0] in_mode;
  logic [IMM_W-1:0]  in_imm;
  logic [DATA_W-1:0] in_word;
  logic [OFF_W-1:0]  in_off;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_err;

  modport master (
    output in_valid, in_mode, in_imm, in_word, in_off, flush, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  in_valid, in_mode, in_imm, in_word, in_off, flush, out_ready,
    output in_ready, out_valid, out_data, out_err
  );
endinterface
`default_nettype wire

// File: rtl/ext_core.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ext_core : combinational immediate / load-data extender               |
// | Rev 1.0 : initial release                                             |
// +-----------------------------------------------------------------------+
module ext_core
  import ext_pkg::*;
#(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32,
  parameter int OFF_W  = $clog2(DATA_W/8)
) (
  input  logic [MODE_W-1:0] mode_i,
  input  logic [IMM_W-1:0]  imm_i,
  input  logic [DATA_W-1:0] word_i,
  input  logic [OFF_W-1:0]  off_i,
  output logic [DATA_W-1:0] data_o,
  output logic              err_o
);

  logic [DATA_W-1:0] w_sext;
  logic [DATA_W-1:0] w_zext;
  logic [15:0]       w_half;
  logic [7:0]        w_byte;
  logic              w_misaligned;

  assign w_sext = {{(DATA_W-IMM_W){imm_i[IMM_W-1]}}, imm_i};
  assign w_zext = {{(DATA_W-IMM_W){1'b0}}, imm_i};

  // Shifting the word down zero-fills, so a halfword at the top byte lane
  // never reads past the word; that offset is odd and reports err anyway.
  assign w_half = 16'(word_i >> {off_i, 3'b000});
  assign w_byte = w_half[7:0];

  assign w_misaligned = mode_i[2] & mode_i[1] & off_i[0];

  always_comb begin
    data_o = '0;
    err_o  = 1'b0;
    case (ext_mode_e'(mode_i))
      EXT_ZERO: data_o = w_zext;
      EXT_SIGN: data_o = w_sext;
      EXT_LUI:  data_o = w_sext << IMM_W;
      EXT_BOFF: data_o = w_sext << 2;
      EXT_LB:   data_o = {{(DATA_W-8){w_byte[7]}}, w_byte};
      EXT_LBU:  data_o = {{(DATA_W-8){1'b0}}, w_byte};
      EXT_LH:   data_o = {{(DATA_W-16){w_half[15]}}, w_half};
      EXT_LHU:  data_o = {{(DATA_W-16){1'b0}}, w_half};
      default:  data_o = '0;
    endcase
    if (w_misaligned) begin
      data_o = '0;
      err_o  = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ext_stage.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ext_stage : extender followed by a 2-entry skid buffer                |
// | Rev 1.0 : initial release                                             |
// +-----------------------------------------------------------------------+
module ext_stage
  import ext_pkg::*;
#(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32,
  parameter int OFF_W  = $clog2(DATA_W/8)
) (
  input  logic clk,
  input  logic reset,
  ext_if.slave bus
);

  logic [DATA_W-1:0] w_data;
  logic              w_err;
  logic [DATA_W:0]   w_entry;
  logic              w_accept;
  logic              w_pop;

  skid_state_e       state_q;
  logic [DATA_W:0]   head_q;
  logic [DATA_W:0]   tail_q;

  ext_core #(
    .IMM_W  (IMM_W),
    .DATA_W (DATA_W),
    .OFF_W  (OFF_W)
  ) u_core (
    .mode_i (bus.in_mode),
    .imm_i  (bus.in_imm),
    .word_i (bus.in_word),
    .off_i  (bus.in_off),
    .data_o (w_data),
    .err_o  (w_err)
  );

  assign w_entry  = {w_err, w_data};
  assign w_accept = bus.in_valid & bus.in_ready;
  assign w_pop    = bus.out_valid & bus.out_ready;

  // Handshake outputs come straight from registers: no input-to-output path.
  assign bus.in_ready  = (state_q != TWO);
  assign bus.out_valid = (state_q != EMPTY);
  assign bus.out_data  = head_q[DATA_W-1:0];
  assign bus.out_err   = head_q[DATA_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else if (bus.flush) begin
      state_q <= EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (w_accept) begin
            head_q  <= w_entry;
            state_q <= ONE;
          end
        end
        ONE: begin
          if (w_accept && w_pop) begin
            head_q <= w_entry;
          end else if (w_accept) begin
            tail_q  <= w_entry;
            state_q <= TWO;
          end else if (w_pop) begin
            state_q <= EMPTY;
          end
        end
        TWO: begin
          if (w_pop) begin
            head_q  <= tail_q;
            state_q <= ONE;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ext_stage.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_ext_stage : directed self-checking bench for ext_stage             |
// | Rev 1.0 : initial release                                             |
// +-----------------------------------------------------------------------+
module tb_ext_stage;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  ext_if #(.IMM_W(16), .DATA_W(32)) bus32 ();
  ext_if #(.IMM_W(16), .DATA_W(64)) bus64 ();

  ext_stage #(.IMM_W(16), .DATA_W(32)) u_dut32 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus32)
  );

  ext_stage #(.IMM_W(16), .DATA_W(64)) u_dut64 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive32(input logic [2:0] mode, input logic [15:0] imm,
                         input logic [31:0] word, input logic [1:0] off);
    bus32.in_valid = 1'b1;
    bus32.in_mode  = mode;
    bus32.in_imm   = imm;
    bus32.in_word  = word;
    bus32.in_off   = off;
  endtask

  // Single beat with out_ready high: visible right after the accept edge,
  // gone after the following edge.
  task automatic send32(input string tag, input logic [2:0] mode, input logic [15:0] imm,
                        input logic [31:0] word, input logic [1:0] off,
                        input logic [31:0] exp_data, input logic exp_err);
    drive32(mode, imm, word, off);
    check({tag, ".ready"}, 64'(bus32.in_ready), 64'd1);
    tick();
    bus32.in_valid = 1'b0;
    check({tag, ".valid"}, 64'(bus32.out_valid), 64'd1);
    check({tag, ".data"},  64'(bus32.out_data), 64'(exp_data));
    check({tag, ".err"},   64'(bus32.out_err), 64'(exp_err));
    tick();
    check({tag, ".drain"}, 64'(bus32.out_valid), 64'd0);
  endtask

  task automatic send64(input string tag, input logic [2:0] mode, input logic [15:0] imm,
                        input logic [63:0] word, input logic [2:0] off,
                        input logic [63:0] exp_data);
    bus64.in_valid = 1'b1;
    bus64.in_mode  = mode;
    bus64.in_imm   = imm;
    bus64.in_word  = word;
    bus64.in_off   = off;
    tick();
    bus64.in_valid = 1'b0;
    check({tag, ".valid"}, 64'(bus64.out_valid), 64'd1);
    check({tag, ".data"},  bus64.out_data, exp_data);
    check({tag, ".err"},   64'(bus64.out_err), 64'd0);
    tick();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    bus32.in_valid = 1'b0; bus32.in_mode = '0; bus32.in_imm = '0;
    bus32.in_word  = '0;   bus32.in_off  = '0; bus32.flush = 1'b0;
    bus32.out_ready = 1'b1;
    bus64.in_valid = 1'b0; bus64.in_mode = '0; bus64.in_imm = '0;
    bus64.in_word  = '0;   bus64.in_off  = '0; bus64.flush = 1'b0;
    bus64.out_ready = 1'b1;

    reset = 1'b1;
    #2;
    check("rst.valid", 64'(bus32.out_valid), 64'd0);
    check("rst.ready", 64'(bus32.in_ready), 64'd1);
    check("rst.data",  64'(bus32.out_data), 64'd0);
    check("rst.err",   64'(bus32.out_err), 64'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Immediate modes
    send32("zext", 3'b000, 16'h8001, 32'h0, 2'd0, 32'h00008001, 1'b0);
    send32("sext", 3'b001, 16'h8001, 32'h0, 2'd0, 32'hFFFF8001, 1'b0);
    send32("lui",  3'b010, 16'h1234, 32'h0, 2'd0, 32'h12340000, 1'b0);
    send32("boff", 3'b011, 16'hFFFF, 32'h0, 2'd0, 32'hFFFFFFFC, 1'b0);

    // Loads from 32'h80FF7F01
    send32("lb2",  3'b100, 16'h0, 32'h80FF7F01, 2'd2, 32'hFFFFFFFF, 1'b0);
    send32("lbu3", 3'b101, 16'h0, 32'h80FF7F01, 2'd3, 32'h00000080, 1'b0);
    send32("lh2",  3'b110, 16'h0, 32'h80FF7F01, 2'd2, 32'hFFFF80FF, 1'b0);
    send32("lhu0", 3'b111, 16'h0, 32'h80FF7F01, 2'd0, 32'h00007F01, 1'b0);
    send32("lh1",  3'b110, 16'h0, 32'h80FF7F01, 2'd1, 32'h00000000, 1'b1);
    send32("lhu3", 3'b111, 16'h0, 32'h80FF7F01, 2'd3, 32'h00000000, 1'b1);

    // Backpressure: A, B fill the buffer, C is held off
    bus32.out_ready = 1'b0;
    drive32(3'b000, 16'h000A, 32'h0, 2'd0);
    tick();
    check("bp.A.ready", 64'(bus32.in_ready), 64'd1);
    check("bp.A.head",  64'(bus32.out_data), 64'h0000000A);
    drive32(3'b000, 16'h000B, 32'h0, 2'd0);
    tick();
    check("bp.B.ready", 64'(bus32.in_ready), 64'd0);
    drive32(3'b000, 16'h000C, 32'h0, 2'd0);
    tick();
    check("bp.C.held",  64'(bus32.in_ready), 64'd0);
    check("bp.hold",    64'(bus32.out_data), 64'h0000000A);
    bus32.out_ready = 1'b1;
    tick();
    check("bp.outB.valid", 64'(bus32.out_valid), 64'd1);
    check("bp.outB",       64'(bus32.out_data), 64'h0000000B);
    check("bp.outB.ready", 64'(bus32.in_ready), 64'd1);
    tick();
    bus32.in_valid = 1'b0;
    check("bp.outC.valid", 64'(bus32.out_valid), 64'd1);
    check("bp.outC",       64'(bus32.out_data), 64'h0000000C);
    tick();
    check("bp.empty", 64'(bus32.out_valid), 64'd0);

    // Flush in TWO with a concurrent in_valid
    bus32.out_ready = 1'b0;
    drive32(3'b000, 16'h000D, 32'h0, 2'd0);
    tick();
    drive32(3'b000, 16'h000E, 32'h0, 2'd0);
    tick();
    check("fl.two", 64'(bus32.in_ready), 64'd0);
    drive32(3'b000, 16'h000F, 32'h0, 2'd0);
    bus32.flush = 1'b1;
    tick();
    bus32.flush = 1'b0;
    bus32.in_valid = 1'b0;
    check("fl.valid", 64'(bus32.out_valid), 64'd0);
    check("fl.ready", 64'(bus32.in_ready), 64'd1);
    bus32.out_ready = 1'b1;
    tick();
    check("fl.stay", 64'(bus32.out_valid), 64'd0);

    // Flush in ONE with a concurrent accept: the new beat is discarded
    bus32.out_ready = 1'b0;
    drive32(3'b000, 16'h0011, 32'h0, 2'd0);
    tick();
    drive32(3'b000, 16'h0022, 32'h0, 2'd0);
    bus32.flush = 1'b1;
    tick();
    bus32.flush = 1'b0;
    bus32.in_valid = 1'b0;
    check("fl1.valid", 64'(bus32.out_valid), 64'd0);
    bus32.out_ready = 1'b1;
    tick();
    check("fl1.stay", 64'(bus32.out_valid), 64'd0);

    // Asynchronous reset between edges while in ONE
    bus32.out_ready = 1'b0;
    drive32(3'b000, 16'h0055, 32'h0, 2'd0);
    tick();
    bus32.in_valid = 1'b0;
    check("ar.one", 64'(bus32.out_valid), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("ar.valid", 64'(bus32.out_valid), 64'd0);
    check("ar.data",  64'(bus32.out_data), 64'd0);
    check("ar.ready", 64'(bus32.in_ready), 64'd1);
    #1;
    reset = 1'b0;
    tick();
    bus32.out_ready = 1'b1;
    send32("ar.after", 3'b001, 16'h7FFF, 32'h0, 2'd0, 32'h00007FFF, 1'b0);

    // 64-bit datapath
    send64("w64.lbu7", 3'b101, 16'h0,    64'h0123456789ABCDEF, 3'd7, 64'h0000000000000001);
    send64("w64.lui",  3'b010, 16'h8000, 64'h0,                3'd0, 64'hFFFFFFFF80000000);
    send64("w64.lh4",  3'b110, 16'h0,    64'h0123456789ABCDEF, 3'd4, 64'h0000000000004567);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ext_stage.md
Name: ext_stage

Overview:
- Registered, flow-controlled extension stage for the pipelined datapath.
- Replaces the single-cycle immediate extender.
- Handles two kinds of operand:
  - Immediate operands: zero-extend, sign-extend, lui, branch offset.
  - Load-data operands: lb/lbu/lh/lhu byte or halfword extraction from a memory word, then extension.
- Sits between the operand-fetch and execute/writeback stages. A 2-entry skid buffer absorbs downstream stalls without a combinational ready path.

Parameters:
- IMM_W, 16, immediate field width; DATA_W must be at least 2*IMM_W.
- DATA_W, 32, datapath and memory-word width; must be 32 or 64.
- OFF_W, $clog2(DATA_W/8), width of the byte-offset field of the address.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  input beat is valid.
- in_ready  output  1  stage can accept a beat.
- in_mode  input  3  ExtCtrl mode; encodings under Behaviour.
- in_imm  input  IMM_W  immediate field.
- in_word  input  DATA_W  memory read word, used by load modes only.
- in_off  input  OFF_W  low address bits, used by load modes only.
- flush  input  1  synchronous discard of all buffered beats.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- out_data  output  DATA_W  extended result.
- out_err  output  1  misaligned halfword load flag, qualified by out_valid.

Behaviour:
- Mode encodings and results (I = in_imm, s = I[IMM_W-1]):
  - 000: zero-extend I.
  - 001: sign-extend I.
  - 010: lui. Result is {sign-fill from s, I, IMM_W zeros}. For DATA_W=32 this is exactly {I,16'b0}.
  - 011: branch offset, sign-extend(I) << 2; bits shifted out above DATA_W are dropped.
  - 100: lb. Byte at in_word[8*in_off +: 8], sign-extended.
  - 101: lbu. Same byte, zero-extended.
  - 110: lh. Halfword at in_word[8*in_off +: 16], sign-extended. Requires in_off[0]=0.
  - 111: lhu. Same halfword, zero-extended.
- Misaligned halfword (modes 110/111 with in_off[0]=1): result 0, err=1. For all other cases err=0.
- For modes 0xx, in_word and in_off are ignored.
- Computation is combinational on the input side; each buffer entry holds the final {data, err}.
- Handshake:
  - Accept = in_valid & in_ready.
  - Pop = out_valid & out_ready.
  - Senders hold inputs stable while in_valid=1 and in_ready=0.
- States:
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: out_valid=1, in_ready=1.
  - TWO: out_valid=1, in_ready=0.
  - in_ready = (state != TWO), decoded directly from the state register.
- Transitions:
  - EMPTY: accept -> ONE.
  - ONE: accept & pop -> ONE with the new beat at head; accept only -> TWO with the new beat in the second slot; pop only -> EMPTY.
  - TWO: pop -> ONE with the second slot promoted to head; accept is impossible.
- Latency: a beat accepted at edge N appears on out_data/out_valid immediately after edge N when the buffer was EMPTY or popped at N. Throughput is 1 beat/cycle with out_ready held high.
- Ordering: strict FIFO; no beat is lost or duplicated.
- Flush:
  - At the edge it is sampled, state goes to EMPTY.
  - A simultaneous accept is discarded.
  - A simultaneous pop completes from the consumer's view; the consumer owns that.
- Reset:
  - Asynchronous assertion immediately forces state=EMPTY, out_valid=0, out_data=0, out_err=0, in_ready=1.
  - Storage entries clear to 0.
  - A reset mid-transfer drops all buffered beats.
- out_data and out_err hold their values while out_valid=1 and out_ready=0.

Decomposition:
- Package ext_pkg:
  - ext_mode_e enum with the 8 mode encodings (EXT_ZERO, EXT_SIGN, EXT_LUI, EXT_BOFF, EXT_LB, EXT_LBU, EXT_LH, EXT_LHU).
  - skid_state_e enum (EMPTY, ONE, TWO).
- Sub-module ext_core: purely combinational mode/offset -> {data, err}, parametrised by IMM_W and DATA_W.
- ext_stage itself contains only the skid buffer and control.

Test Plan:
- Reset, then single beats at DATA_W=32 with out_ready=1, each appearing one cycle after accept:
  - mode 000, imm 16'h8001 -> 32'h00008001.
  - mode 001, imm 16'h8001 -> 32'hFFFF8001.
  - mode 010, imm 16'h1234 -> 32'h12340000.
  - mode 011, imm 16'hFFFF -> 32'hFFFFFFFC.
- Loads, word 32'h80FF7F01:
  - lb off 2 -> 32'hFFFFFFFF.
  - lbu off 3 -> 32'h00000080.
  - lh off 2 -> 32'hFFFF80FF.
  - lhu off 0 -> 32'h00007F01.
  - lh off 1 -> out_data 0, out_err=1.
- Backpressure:
  - Hold out_ready=0 and send 3 beats back-to-back -> in_ready drops after the 2nd accept and the 3rd is held.
  - Raise out_ready -> results emerge in order A, B, C with no gaps or duplicates.
- Flush in TWO state with in_valid=1 on the same edge -> next cycle out_valid=0 and in_ready=1; the flushed and concurrent beats never appear.
- Assert reset asynchronously between edges while in ONE -> out_valid falls before the next clk edge; the first beat after deassertion is accepted normally.
- DATA_W=64, word 64'h0123456789ABCDEF:
  - lbu off 7 -> 64'h01.
  - mode 010, imm 16'h8000 -> 64'hFFFFFFFF80000000.
